// File: rtl/wb_group_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_group_arbiter
// Purpose  : Round-robin arbiter sharing one registered writeback port among
//            the multicycle units of a writeback group.
// Revision : 1.0 - initial release
// ============================================================================
module wb_group_arbiter #(
    parameter int NUM_UNITS = 4,
    parameter int ID_W      = 3,
    parameter int DATA_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_UNITS-1:0]        unit_done,
    input  logic [NUM_UNITS*ID_W-1:0]   unit_id,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_rd,
    output logic [NUM_UNITS-1:0]        unit_ack,
    input  logic                        wb_hold,
    output logic                        wb_valid,
    output logic [ID_W-1:0]             wb_id,
    output logic [DATA_W-1:0]           wb_data
);

    localparam int          c_PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(NUM_UNITS - 1);

    logic                r_valid;
    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_data;
    logic [c_PTR_W-1:0]  r_ptr;

    logic                w_load;
    logic                w_found;
    logic                w_fire;
    logic [c_PTR_W-1:0]  w_gnt;
    logic [c_PTR_W-1:0]  w_ptr_nxt;
    int                  w_idx;

    assign w_load = ~r_valid | ~wb_hold;

    // Cyclic scan starting at r_ptr; the first requester found wins.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = 0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_UNITS) w_idx = w_idx - NUM_UNITS;
            if (!w_found && unit_done[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = c_PTR_W'(w_idx);
            end
        end
    end

    assign w_fire    = w_load & w_found & ~rst;
    assign w_ptr_nxt = (w_gnt == c_LAST) ? '0 : w_gnt + 1'b1;

    generate
        for (genvar i = 0; i < NUM_UNITS; i++) begin : g_ack
            assign unit_ack[i] = w_fire && (w_gnt == c_PTR_W'(i));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            r_data  <= '0;
            r_ptr   <= '0;
        end else if (w_load) begin
            if (w_found) begin
                r_valid <= 1'b1;
                r_id    <= unit_id[w_gnt*ID_W +: ID_W];
                r_data  <= unit_rd[w_gnt*DATA_W +: DATA_W];
                r_ptr   <= w_ptr_nxt;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign wb_valid = r_valid;
    assign wb_id    = r_id;
    assign wb_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_wb_group_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_group_arbiter
// Purpose  : Self-checking bench for wb_group_arbiter (model plus directed).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_group_arbiter;

    localparam int N  = 4;
    localparam int IW = 3;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    unit_done;
    logic [N*IW-1:0] unit_id;
    logic [N*DW-1:0] unit_rd;
    logic [N-1:0]    unit_ack;
    logic            wb_hold;
    logic            wb_valid;
    logic [IW-1:0]   wb_id;
    logic [DW-1:0]   wb_data;

    int total = 0;
    int bad   = 0;

    wb_group_arbiter #(.NUM_UNITS(N), .ID_W(IW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .unit_done(unit_done),
        .unit_id  (unit_id),
        .unit_rd  (unit_rd),
        .unit_ack (unit_ack),
        .wb_hold  (wb_hold),
        .wb_valid (wb_valid),
        .wb_id    (wb_id),
        .wb_data  (wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Behavioural model: output register plus pointer, advanced once per cycle
    // from the inputs visible at the falling edge.
    logic          m_known = 1'b0;
    logic          m_valid;
    logic [IW-1:0] m_id;
    logic [DW-1:0] m_data;
    int            m_ptr;

    always @(negedge clk) begin
        logic         ld;
        int           g;
        logic [N-1:0] exp_ack;
        ld = !m_known || !m_valid || !wb_hold;
        g  = -1;
        if (!rst && ld) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && unit_done[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        exp_ack = (g >= 0) ? N'(1 << g) : '0;
        if (m_known || rst) chk("model_ack", 64'(unit_ack), 64'(exp_ack));
        if (m_known) begin
            chk("model_valid", 64'(wb_valid), 64'(m_valid));
            chk("model_id",    64'(wb_id),    64'(m_id));
            chk("model_data",  64'(wb_data),  64'(m_data));
        end
        if (rst) begin
            m_known = 1'b1;
            m_valid = 1'b0;
            m_id    = '0;
            m_data  = '0;
            m_ptr   = 0;
        end else if (m_known && ld) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_id    = unit_id[g*IW +: IW];
                m_data  = unit_rd[g*DW +: DW];
                m_ptr   = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        unit_done = '0;
        wb_hold   = 1'b0;
        unit_id   = {3'd6, 3'd5, 3'd1, 3'd4};
        unit_rd   = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h1000_0000};
        cyc(); cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", 64'(wb_valid), 64'd0);
        chk("reset_id",    64'(wb_id),    64'd0);
        chk("reset_data",  64'(wb_data),  64'd0);

        // Single request to unit 2
        cyc(); unit_done = 4'b0100;
        @(negedge clk); chk("single_ack", 64'(unit_ack), 64'h4);
        cyc(); unit_done = 4'b0000;
        @(negedge clk);
        chk("single_valid", 64'(wb_valid), 64'd1);
        chk("single_id",    64'(wb_id),    64'd5);
        chk("single_data",  64'(wb_data),  64'hDEAD_BEEF);

        // Pointer sits at 3: unit 3 beats unit 0, then wraps to unit 0
        cyc(); unit_done = 4'b1001;
        @(negedge clk); chk("wrap_ack3", 64'(unit_ack), 64'h8);
        cyc(); unit_done = 4'b0001;
        @(negedge clk);
        chk("wrap_ack0", 64'(unit_ack), 64'h1);
        chk("wrap_id3",  64'(wb_id),    64'd6);
        cyc(); unit_done = 4'b0000;
        @(negedge clk); chk("wrap_id0", 64'(wb_id), 64'd4);

        // Idle drain: valid drops, payload retained
        cyc();
        @(negedge clk);
        chk("drain_valid", 64'(wb_valid), 64'd0);
        chk("drain_id",    64'(wb_id),    64'd4);
        chk("drain_data",  64'(wb_data),  64'h1000_0000);

        // Hold: unit 1 result held for 3 cycles while unit 3 waits
        cyc(); unit_done = 4'b0010;
        @(negedge clk); chk("hold_pre_ack", 64'(unit_ack), 64'h2);
        cyc(); unit_done = 4'b1000; wb_hold = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("hold_ack", 64'(unit_ack), 64'h0);
            chk("hold_id",  64'(wb_id),    64'd1);
            chk("hold_val", 64'(wb_valid), 64'd1);
            cyc();
        end
        wb_hold = 1'b0;
        @(negedge clk); chk("hold_release_ack", 64'(unit_ack), 64'h8);
        cyc(); unit_done = 4'b0000;
        @(negedge clk); chk("hold_release_id", 64'(wb_id), 64'd6);

        // Reset mid-stream with all units pending
        cyc(); unit_done = 4'b1111; rst = 1'b1;
        @(negedge clk); chk("rst_ack", 64'(unit_ack), 64'h0);
        cyc(); rst = 1'b0; wb_hold = 1'b1;

        // Continuous requests from ptr=0; hold ignored while output empty
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (j == 0) chk("post_rst_valid", 64'(wb_valid), 64'd0);
            chk("rr_ack", 64'(unit_ack), 64'(1 << (j % 4)));
            if (j > 0) chk("rr_id", 64'(wb_id), 64'(unit_id[((j - 1) % 4)*IW +: IW]));
            cyc();
            wb_hold = 1'b0;
        end
        unit_done = 4'b0000;
        @(negedge clk); chk("rr_last_id", 64'(wb_id), 64'd6);

        // Mixed tail exercised only through the model
        cyc(); unit_done = 4'b0110; wb_hold = 1'b1;
        cyc(); wb_hold = 1'b0;
        cyc(); unit_done = 4'b0100;
        cyc(); unit_done = 4'b0000;
        cyc(); cyc();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
